// File: rtl/victim_pkg.sv
// Shared types and default geometry for the L1/L2 victim buffer controller.
package victim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL,
        RESP,
        FL_SCAN,
        FL_WB
    } state_e;

    localparam int DEF_ENTRIES   = 4;
    localparam int DEF_ADDR_BITS = 32;
    localparam int DEF_LINE_BITS = 256;
    localparam int DEF_CNT_BITS  = 16;
    localparam int DEF_OFFSET    = $clog2(DEF_LINE_BITS / 8);
    localparam int DEF_IDX_BITS  = $clog2(DEF_ENTRIES);

    typedef logic [DEF_LINE_BITS-1:0] line_t;
    typedef logic [DEF_IDX_BITS-1:0]  slot_t;

endpackage

// File: rtl/victim_lru.sv
// Age-based LRU tracker: ages form a permutation, age 0 is MRU, age ENTRIES-1 is LRU.
module victim_lru #(
    parameter int ENTRIES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_touch,
    input  logic [$clog2(ENTRIES)-1:0] i_touch_idx,
    output logic [$clog2(ENTRIES)-1:0] o_lru_idx
);
    localparam int IDX = $clog2(ENTRIES);

    logic [IDX-1:0] r_age [ENTRIES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) r_age[i] <= IDX'(i);
        end else if (i_touch) begin
            // Everything younger than the touched slot ages by one; the permutation is preserved.
            for (int i = 0; i < ENTRIES; i++) begin
                if (IDX'(i) == i_touch_idx)
                    r_age[i] <= '0;
                else if (r_age[i] < r_age[i_touch_idx])
                    r_age[i] <= r_age[i] + IDX'(1);
            end
        end
    end

    always_comb begin
        o_lru_idx = '0;
        for (int i = 0; i < ENTRIES; i++)
            if (r_age[i] == IDX'(ENTRIES - 1)) o_lru_idx = IDX'(i);
    end

endmodule

// File: rtl/victim_buffer_ctrl.sv
// Fully associative exclusive victim buffer between L1 and L2: swap on hit,
// fill from L2 on miss, write back dirty victims on replacement and flush.
module victim_buffer_ctrl
    import victim_pkg::*;
#(
    parameter int ENTRIES   = DEF_ENTRIES,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int CNT_BITS  = DEF_CNT_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 l1_req,
    input  logic [ADDR_BITS-1:0] l1_addr,
    input  logic                 evict_valid,
    input  logic [ADDR_BITS-1:0] evict_addr,
    input  logic [LINE_BITS-1:0] evict_data,
    input  logic                 evict_dirty,
    output logic [LINE_BITS-1:0] l1_rdata,
    output logic                 l1_resp,
    output logic                 l2_read,
    output logic                 l2_write,
    output logic [ADDR_BITS-1:0] l2_addr,
    output logic [LINE_BITS-1:0] l2_wdata,
    input  logic [LINE_BITS-1:0] l2_rdata,
    input  logic                 l2_resp,
    input  logic                 flush_req,
    output logic                 flush_done,
    output logic [CNT_BITS-1:0]  hit_count,
    output logic [CNT_BITS-1:0]  miss_count,
    output state_e               dbg_state
);
    localparam int OFFSET = $clog2(LINE_BITS / 8);
    localparam int TAG    = ADDR_BITS - OFFSET;
    localparam int IDX    = $clog2(ENTRIES);

    state_e               r_state, w_next;
    logic [ENTRIES-1:0]   r_valid, r_dirty;
    logic [TAG-1:0]       r_tag  [ENTRIES];
    logic [LINE_BITS-1:0] r_data [ENTRIES];
    logic [IDX-1:0]       r_slot;
    logic [LINE_BITS-1:0] r_rdata, r_l2_wdata;
    logic [ADDR_BITS-1:0] r_l2_addr;
    logic                 r_l1_resp, r_l2_read, r_l2_write, r_flush_done;
    logic [CNT_BITS-1:0]  r_hit_cnt, r_miss_cnt;

    logic [TAG-1:0] w_req_tag, w_ev_tag;
    logic           w_hit, w_free, w_fl_found, w_lookup, w_touch, w_wr_en;
    logic [IDX-1:0] w_hit_idx, w_free_idx, w_fl_idx, w_target, w_lru_idx;
    logic [IDX-1:0] w_wb_idx, w_touch_idx;
    logic           w_unused_offsets;

    assign w_req_tag        = l1_addr[ADDR_BITS-1:OFFSET];
    assign w_ev_tag         = evict_addr[ADDR_BITS-1:OFFSET];
    assign w_unused_offsets = ^{l1_addr[OFFSET-1:0], evict_addr[OFFSET-1:0]};
    assign w_lookup         = (r_state == IDLE) && l1_req;

    // Descending scans leave the lowest matching index in each result.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        w_fl_found = 1'b0;
        w_fl_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == w_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX'(i);
            end
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX'(i);
            end
            if (r_valid[i] && r_dirty[i]) begin
                w_fl_found = 1'b1;
                w_fl_idx   = IDX'(i);
            end
        end
        w_target = w_free ? w_free_idx : w_lru_idx;
    end

    assign w_wb_idx    = (r_state == FL_SCAN) ? w_fl_idx : w_target;
    assign w_touch_idx = (r_state == IDLE) ? w_hit_idx : r_slot;
    assign w_wr_en     = evict_valid && ((w_lookup && w_hit) || ((r_state == FILL) && l2_resp));
    assign w_touch     = (w_lookup && w_hit) || ((r_state == FILL) && l2_resp && evict_valid);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (l1_req) begin
                    if (w_hit)
                        w_next = RESP;
                    else if (evict_valid && r_valid[w_target] && r_dirty[w_target])
                        w_next = WB;
                    else
                        w_next = FILL;
                end else if (flush_req) begin
                    w_next = FL_SCAN;
                end
            end
            WB:      if (l2_resp) w_next = FILL;
            FILL:    if (l2_resp) w_next = RESP;
            RESP:    w_next = IDLE;
            FL_SCAN: w_next = w_fl_found ? FL_WB : IDLE;
            FL_WB:   if (l2_resp) w_next = FL_SCAN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Strobes are registered from the next state so they rise on state entry
    // and fall the cycle after l2_resp is sampled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= '0;
            r_dirty      <= '0;
            r_slot       <= '0;
            r_rdata      <= '0;
            r_l1_resp    <= 1'b0;
            r_l2_read    <= 1'b0;
            r_l2_write   <= 1'b0;
            r_l2_addr    <= '0;
            r_l2_wdata   <= '0;
            r_flush_done <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_l1_resp    <= (w_next == RESP);
            r_l2_read    <= (w_next == FILL);
            r_l2_write   <= (w_next == WB) || (w_next == FL_WB);
            r_flush_done <= (r_state == FL_SCAN) && !w_fl_found;

            if (w_lookup) begin
                if (w_hit) begin
                    if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_BITS'(1);
                    r_rdata <= r_data[w_hit_idx];
                    if (!evict_valid) begin
                        r_valid[w_hit_idx] <= 1'b0;
                        r_dirty[w_hit_idx] <= 1'b0;
                    end
                end else begin
                    if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_BITS'(1);
                    r_slot <= w_target;
                end
            end

            if (r_state == FL_SCAN) r_slot <= w_fl_idx;

            if (((r_state == IDLE) && (w_next == WB)) || ((r_state == FL_SCAN) && (w_next == FL_WB))) begin
                r_l2_addr  <= {r_tag[w_wb_idx], {OFFSET{1'b0}}};
                r_l2_wdata <= r_data[w_wb_idx];
            end
            if ((w_next == FILL) && (r_state != FILL))
                r_l2_addr <= {w_req_tag, {OFFSET{1'b0}}};

            if ((r_state == FILL) && l2_resp) r_rdata <= l2_rdata;

            if (w_wr_en) begin
                r_valid[w_touch_idx] <= 1'b1;
                r_dirty[w_touch_idx] <= evict_dirty;
            end

            if ((r_state == FL_WB) && l2_resp) r_dirty[r_slot] <= 1'b0;

            if ((r_state == FL_SCAN) && !w_fl_found) begin
                r_valid <= '0;
                r_dirty <= '0;
            end
        end
    end

    // Line storage carries no reset; valid bits qualify every read.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_tag[w_touch_idx]  <= w_ev_tag;
            r_data[w_touch_idx] <= evict_data;
        end
    end

    victim_lru #(.ENTRIES(ENTRIES)) u_lru (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_touch     (w_touch),
        .i_touch_idx (w_touch_idx),
        .o_lru_idx   (w_lru_idx)
    );

    assign l1_rdata   = r_rdata;
    assign l1_resp    = r_l1_resp;
    assign l2_read    = r_l2_read;
    assign l2_write   = r_l2_write;
    assign l2_addr    = r_l2_addr;
    assign l2_wdata   = r_l2_wdata;
    assign flush_done = r_flush_done;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
    assign dbg_state  = r_state;

endmodule
